// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: op encoding,
// default widths and the hard-wired zero register address.
package regfile_access_ctrl_pkg;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int X0_ADDR = 0;

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
endpackage

// File: rtl/regfile_access_ctrl_wb_queue.sv
// Writeback FIFO with a two-port associative lookup that reports the youngest
// queued entry matching each lookup address.
module wb_queue
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_rd,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_rd,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  input  logic [AW-1:0] look_a1,
  input  logic [AW-1:0] look_a2,
  output logic          hit1,
  output logic          hit2,
  output logic [DW-1:0] hit_data1,
  output logic [DW-1:0] hit_data2
);
  logic [AW-1:0] rd_mem_r   [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  assign count     = count_r;
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign head_rd   = rd_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: validity is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_r[wr_ptr_r]   <= push_rd;
      data_mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    hit_data1 = '0;
    hit_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_r) begin
        if (rd_mem_r[rd_ptr_r + PW'(i)] == look_a1) begin
          hit1      = 1'b1;
          hit_data1 = data_mem_r[rd_ptr_r + PW'(i)];
        end else begin
          hit1      = hit1;
        end
        if (rd_mem_r[rd_ptr_r + PW'(i)] == look_a2) begin
          hit2      = 1'b1;
          hit_data2 = data_mem_r[rd_ptr_r + PW'(i)];
        end else begin
          hit2      = hit2;
        end
      end else begin
        hit1 = hit1;
      end
    end
  end
endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: arbitrates one read or one write per cycle, queues
// writebacks and forwards queued/in-flight data so reads are never stale.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int WQ_DEPTH = 4,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  input  logic [AW-1:0]             rd_req_rs1,
  input  logic [AW-1:0]             rd_req_rs2,
  output logic                      rd_rsp_valid,
  output logic [DW-1:0]             rd_rsp_data1,
  output logic [DW-1:0]             rd_rsp_data2,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [AW-1:0]             wb_rd,
  input  logic [DW-1:0]             wb_data,
  output logic                      rf_en,
  output logic                      rf_RWen,
  output logic [AW-1:0]             rf_rs1,
  output logic [AW-1:0]             rf_rs2,
  output logic [AW-1:0]             rf_rd,
  output logic [DW-1:0]             rf_dataIn,
  input  logic [DW-1:0]             rf_readOut1,
  input  logic [DW-1:0]             rf_readOut2,
  output logic [$clog2(WQ_DEPTH):0] wq_count
);
  localparam int CW = $clog2(WQ_DEPTH) + 1;

  logic          full_s, empty_s, push_s, pop_s, rd_go_s, wr_go_s;
  logic [1:0]    op_s;
  logic [AW-1:0] head_rd_s;
  logic [DW-1:0] head_data_s;
  logic [CW-1:0] count_s;
  logic          qhit1_s, qhit2_s, fhit1_s, fhit2_s;
  logic [DW-1:0] qdata1_s, qdata2_s, fdata1_s, fdata2_s;
  logic          rsp_valid_r, fhit1_r, fhit2_r;
  logic [DW-1:0] fdata1_r, fdata2_r;

  assign rd_go_s = !reset && rd_req_valid && !full_s;
  assign wr_go_s = !reset && !rd_go_s && !empty_s;
  assign pop_s   = wr_go_s;
  assign push_s  = !reset && wb_valid && !full_s && (wb_rd != AW'(X0_ADDR));

  assign rd_req_ready = !reset && !full_s;
  assign wb_ready     = !reset && !full_s;
  assign wq_count     = reset ? '0 : count_s;

  wb_queue #(.DEPTH(WQ_DEPTH), .AW(AW), .DW(DW)) u_wb_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_rd   (wb_rd),
    .push_data (wb_data),
    .pop       (pop_s),
    .head_rd   (head_rd_s),
    .head_data (head_data_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s),
    .look_a1   (rd_req_rs1),
    .look_a2   (rd_req_rs2),
    .hit1      (qhit1_s),
    .hit2      (qhit2_s),
    .hit_data1 (qdata1_s),
    .hit_data2 (qdata2_s)
  );

  // Op selection and register-file drive; reset forces a clearing write.
  always_comb begin
    op_s      = OP_IDLE;
    rf_en     = 1'b0;
    rf_RWen   = 1'b0;
    rf_rs1    = '0;
    rf_rs2    = '0;
    rf_rd     = '0;
    rf_dataIn = '0;
    if (rd_go_s) begin
      op_s = OP_READ;
    end else if (wr_go_s) begin
      op_s = OP_WRITE;
    end else begin
      op_s = OP_IDLE;
    end
    if (reset) begin
      rf_en   = 1'b1;
      rf_RWen = 1'b0;
    end else begin
      case (op_s)
        OP_READ: begin
          rf_en   = 1'b1;
          rf_RWen = 1'b1;
          rf_rs1  = rd_req_rs1;
          rf_rs2  = rd_req_rs2;
        end
        OP_WRITE: begin
          rf_en     = 1'b1;
          rf_RWen   = 1'b0;
          rf_rd     = head_rd_s;
          rf_dataIn = head_data_s;
        end
        default: rf_en = 1'b0;
      endcase
    end
  end

  // Forward priority: x0, then same-cycle push (youngest), then queue.
  always_comb begin
    fhit1_s  = 1'b0;
    fhit2_s  = 1'b0;
    fdata1_s = '0;
    fdata2_s = '0;
    if (rd_req_rs1 == AW'(X0_ADDR)) begin
      fhit1_s = 1'b1;
    end else if (push_s && (wb_rd == rd_req_rs1)) begin
      fhit1_s  = 1'b1;
      fdata1_s = wb_data;
    end else begin
      fhit1_s  = qhit1_s;
      fdata1_s = qdata1_s;
    end
    if (rd_req_rs2 == AW'(X0_ADDR)) begin
      fhit2_s = 1'b1;
    end else if (push_s && (wb_rd == rd_req_rs2)) begin
      fhit2_s  = 1'b1;
      fdata2_s = wb_data;
    end else begin
      fhit2_s  = qhit2_s;
      fdata2_s = qdata2_s;
    end
  end

  // Capture response valid and forward decision for the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      fhit1_r     <= 1'b0;
      fhit2_r     <= 1'b0;
      fdata1_r    <= '0;
      fdata2_r    <= '0;
    end else begin
      rsp_valid_r <= rd_go_s;
      if (rd_go_s) begin
        fhit1_r  <= fhit1_s;
        fhit2_r  <= fhit2_s;
        fdata1_r <= fdata1_s;
        fdata2_r <= fdata2_s;
      end
    end
  end

  assign rd_rsp_valid = rsp_valid_r && !reset;
  assign rd_rsp_data1 = !rd_rsp_valid ? '0 : (fhit1_r ? fdata1_r : rf_readOut1);
  assign rd_rsp_data2 = !rd_rsp_valid ? '0 : (fhit2_r ? fdata2_r : rf_readOut2);
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural register file plus an
// architectural-state model predicting every read response and rf operation.
module tb_regfile_access_ctrl;
  localparam int WQ_DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_rs1 = '0;
  logic [AW-1:0] rd_req_rs2 = '0;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data1, rd_rsp_data2;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rf_en, rf_RWen;
  logic [AW-1:0] rf_rs1, rf_rs2, rf_rd;
  logic [DW-1:0] rf_dataIn;
  logic [DW-1:0] rf_readOut1 = '0;
  logic [DW-1:0] rf_readOut2 = '0;
  logic [CW-1:0] wq_count;

  regfile_access_ctrl #(.WQ_DEPTH(WQ_DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_rs1(rd_req_rs1), .rd_req_rs2(rd_req_rs2),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data1(rd_rsp_data1), .rd_rsp_data2(rd_rsp_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_en(rf_en), .rf_RWen(rf_RWen), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rd(rf_rd), .rf_dataIn(rf_dataIn),
    .rf_readOut1(rf_readOut1), .rf_readOut2(rf_readOut2),
    .wq_count(wq_count)
  );

  always #5 clk = ~clk;

  // Behavioural register file with registered read outputs.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= '0;
      rf_readOut1 <= '0;
      rf_readOut2 <= '0;
    end else if (rf_en && rf_RWen) begin
      rf_readOut1 <= rf_mem[rf_rs1];
      rf_readOut2 <= rf_mem[rf_rs2];
    end else if (rf_en && (rf_rd != 5'd0)) begin
      rf_mem[rf_rd] <= rf_dataIn;
    end
  end

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] arch [32];
  wb_t           mq [$];
  logic          pend_valid = 1'b0;
  logic [DW-1:0] pend1, pend2;
  logic          racc, wacc;

  task automatic step(input logic rv, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                      output logic ra, output logic wa);
    int            pre;
    logic          full_m, nv;
    logic [DW-1:0] n1, n2;
    @(negedge clk);
    rd_req_valid = rv; rd_req_rs1 = a1; rd_req_rs2 = a2;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    #1;
    total++;
    if (rd_rsp_valid !== pend_valid) begin
      bad++; $display("FAIL rsp_valid got=%0b exp=%0b", rd_rsp_valid, pend_valid);
    end
    if (pend_valid) begin
      total += 2;
      if (rd_rsp_data1 !== pend1) begin
        bad++; $display("FAIL rsp_data1 got=%h exp=%h", rd_rsp_data1, pend1);
      end
      if (rd_rsp_data2 !== pend2) begin
        bad++; $display("FAIL rsp_data2 got=%h exp=%h", rd_rsp_data2, pend2);
      end
    end
    pre = mq.size();
    full_m = (pre == WQ_DEPTH);
    total += 3;
    if (wq_count !== CW'(pre)) begin
      bad++; $display("FAIL wq_count got=%0d exp=%0d", wq_count, pre);
    end
    if (rd_req_ready !== !full_m) begin
      bad++; $display("FAIL rd_req_ready got=%0b exp=%0b", rd_req_ready, !full_m);
    end
    if (wb_ready !== !full_m) begin
      bad++; $display("FAIL wb_ready got=%0b exp=%0b", wb_ready, !full_m);
    end
    ra = rv && !full_m;
    wa = wv && !full_m;
    if (wa && (wr != 5'd0)) begin
      arch[wr] = wd;
      mq.push_back('{rd: wr, data: wd});
    end
    nv = ra;
    n1 = (a1 == 5'd0) ? 32'd0 : arch[a1];
    n2 = (a2 == 5'd0) ? 32'd0 : arch[a2];
    total++;
    if (ra) begin
      if ({rf_en, rf_RWen, rf_rs1, rf_rs2} !== {1'b1, 1'b1, a1, a2}) begin
        bad++; $display("FAIL rf_read got=%b%b/%0d/%0d exp=11/%0d/%0d",
                        rf_en, rf_RWen, rf_rs1, rf_rs2, a1, a2);
      end
    end else if (pre > 0) begin
      if ({rf_en, rf_RWen, rf_rd, rf_dataIn} !== {1'b1, 1'b0, mq[0].rd, mq[0].data}) begin
        bad++; $display("FAIL rf_write got=%b%b/%0d/%h exp=10/%0d/%h",
                        rf_en, rf_RWen, rf_rd, rf_dataIn, mq[0].rd, mq[0].data);
      end
      void'(mq.pop_front());
    end else begin
      if ({rf_en, rf_rs1, rf_rs2, rf_rd, rf_dataIn} !== '0) begin
        bad++; $display("FAIL rf_idle got en=%b rs1=%0d rs2=%0d rd=%0d din=%h exp all 0",
                        rf_en, rf_rs1, rf_rs2, rf_rd, rf_dataIn);
      end
    end
    pend_valid = nv; pend1 = n1; pend2 = n2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, racc, wacc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1);
    idle(1);
    total++;
    if (mq.size() != 0) begin
      bad++; $display("FAIL drain got=%0d entries exp=0", mq.size());
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      reset = 1'b1; rd_req_valid = 1'b0; wb_valid = 1'b0;
      #1;
      total++;
      if ({rf_en, rf_RWen, rd_req_ready, wb_ready, rd_rsp_valid, wq_count,
           rd_rsp_data1, rd_rsp_data2} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0}) begin
        bad++; $display("FAIL reset_state got en=%b rw=%b rr=%b wr=%b rv=%b cnt=%0d d1=%h d2=%h exp 1 0 0 0 0 0 0 0",
                        rf_en, rf_RWen, rd_req_ready, wb_ready, rd_rsp_valid, wq_count,
                        rd_rsp_data1, rd_rsp_data2);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) arch[k] = '0;
    mq.delete();
    pend_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    step(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, racc, wacc);
    idle(1);
  endtask

  task automatic test_write_read();
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, racc, wacc);
    idle(2);
    step(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, racc, wacc);
    idle(1);
  endtask

  task automatic test_same_cycle_fwd();
    step(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h11, racc, wacc);
    idle(1);
    drain();
  endtask

  task automatic test_youngest();
    step(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'd1, racc, wacc);
    step(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'd2, racc, wacc);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, racc, wacc);
    drain();
    total++;
    if (rf_mem[3] !== 32'd2) begin
      bad++; $display("FAIL youngest_rf got=%h exp=2", rf_mem[3]);
    end
  endtask

  task automatic test_full();
    int sent = 0;
    for (int i = 0; i < 30 && sent < WQ_DEPTH + 1; i++) begin
      step(1'b1, 5'(10 + (i % 5)), 5'(14 - (i % 5)), 1'b1, 5'(10 + sent),
           32'hA000 + 32'(sent), racc, wacc);
      if (wacc) sent++;
    end
    total++;
    if (sent != WQ_DEPTH + 1) begin
      bad++; $display("FAIL full_accept got=%0d exp=%0d", sent, WQ_DEPTH + 1);
    end
    drain();
    for (int k = 0; k < WQ_DEPTH + 1; k++) begin
      total++;
      if (rf_mem[10 + k] !== 32'hA000 + 32'(k)) begin
        bad++; $display("FAIL full_data x%0d got=%h exp=%h", 10 + k, rf_mem[10 + k], 32'hA000 + 32'(k));
      end
    end
  endtask

  task automatic test_x0_and_reset();
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, racc, wacc);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, racc, wacc);
    idle(1);
    step(1'b1, 5'd20, 5'd0, 1'b1, 5'd20, 32'h55, racc, wacc);
    step(1'b1, 5'd21, 5'd20, 1'b1, 5'd21, 32'h66, racc, wacc);
    do_reset(1);
    idle(2);
    total++;
    if (rf_mem[20] !== 32'd0 || rf_mem[21] !== 32'd0) begin
      bad++; $display("FAIL reset_drop got=%h/%h exp=0/0", rf_mem[20], rf_mem[21]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom, racc, wacc);
    end
    drain();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (rf_mem[k] !== arch[k]) begin
        bad++; $display("FAIL random_rf x%0d got=%h exp=%h", k, rf_mem[k], arch[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) arch[k] = '0;
    test_reset();
    test_write_read();
    test_same_cycle_fwd();
    test_youngest();
    test_full();
    test_x0_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
